// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer behind the UART receiver: FWFT FIFO with valid/ready read port,
// sticky overflow / framing-error flags and a saturating error-frame counter.
module uart_rx_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_byte_in,
   input  logic                     rx_done_in,
   input  logic                     rx_error_in,
   output logic [7:0]               rd_data_out,
   output logic                     rd_valid_out,
   input  logic                     rd_ready_in,
   output logic [$clog2(DEPTH):0]   count_out,
   output logic                     overflow_out,
   output logic                     frame_err_out,
   output logic [7:0]               err_count_out,
   input  logic                     clear_flags_in,
   input  logic                     flush_in
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push;
   logic        err_frame;
   logic        drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A pop frees a slot in the same cycle, so a full FIFO can still accept the incoming byte.
   assign pop       = !empty && rd_ready_in;
   assign push      = rx_done_in && !rx_error_in && (!full || pop);
   assign err_frame = rx_done_in && rx_error_in;
   assign drop      = rx_done_in && !rx_error_in && full && !pop;

   always_ff @(posedge clk) begin
      if (rst || flush_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush_in && push) mem[wr_ptr[AW-1:0]] <= rx_byte_in;
   end

   // Set/increment events take priority over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_out  <= 1'b0;
         frame_err_out <= 1'b0;
         err_count_out <= 8'h00;
      end else begin
         if (drop)
            overflow_out <= 1'b1;
         else if (clear_flags_in)
            overflow_out <= 1'b0;

         if (err_frame)
            frame_err_out <= 1'b1;
         else if (clear_flags_in)
            frame_err_out <= 1'b0;

         if (clear_flags_in)
            err_count_out <= err_frame ? 8'h01 : 8'h00;
         else if (err_frame && (err_count_out != 8'hFF))
            err_count_out <= err_count_out + 8'h01;
      end
   end

   assign rd_valid_out = !empty;
   assign rd_data_out  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign count_out    = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: the driver keeps a queue-based model and expected byte
// stream; a monitor pops and compares on every accepted read, a status checker compares flags/count.
module tb_uart_rx_buffer;

   localparam int DEPTH = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [7:0]               rx_byte_in = 8'h00;
   logic                     rx_done_in = 1'b0;
   logic                     rx_error_in = 1'b0;
   logic [7:0]               rd_data_out;
   logic                     rd_valid_out;
   logic                     rd_ready_in = 1'b0;
   logic [$clog2(DEPTH):0]   count_out;
   logic                     overflow_out;
   logic                     frame_err_out;
   logic [7:0]               err_count_out;
   logic                     clear_flags_in = 1'b0;
   logic                     flush_in = 1'b0;

   uart_rx_buffer #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_byte_in     (rx_byte_in),
      .rx_done_in     (rx_done_in),
      .rx_error_in    (rx_error_in),
      .rd_data_out    (rd_data_out),
      .rd_valid_out   (rd_valid_out),
      .rd_ready_in    (rd_ready_in),
      .count_out      (count_out),
      .overflow_out   (overflow_out),
      .frame_err_out  (frame_err_out),
      .err_count_out  (err_count_out),
      .clear_flags_in (clear_flags_in),
      .flush_in       (flush_in)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];
   int         m_cnt = 0;
   bit         m_ov = 0;
   bit         m_fe = 0;
   int         m_ec = 0;
   int         pushed = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and advance the reference model to the
   // state the DUT should hold after the next rising edge.
   task automatic step(input bit d, input bit e, input logic [7:0] b, input bit rdy,
                       input bit fl, input bit clr, input bit r);
      bit pop_m;
      bit full_m;
      @(negedge clk);
      rx_done_in = d; rx_error_in = e; rx_byte_in = b; rd_ready_in = rdy;
      flush_in = fl; clear_flags_in = clr; rst = r;
      if (r) begin
         exp_q.delete();
         m_cnt = 0; m_ov = 0; m_fe = 0; m_ec = 0;
      end else begin
         pop_m  = (m_cnt > 0) && rdy;
         full_m = (m_cnt == DEPTH);
         if (clr) begin
            m_ov = 0; m_fe = 0; m_ec = 0;
         end
         if (d && e) begin
            m_fe = 1;
            if (m_ec < 255) m_ec++;
         end
         if (d && !e && full_m && !pop_m) m_ov = 1;
         if (fl) begin
            exp_q.delete();
            m_cnt = 0;
         end else begin
            if (pop_m) m_cnt--;
            if (d && !e && (!full_m || pop_m)) begin
               exp_q.push_back(b);
               m_cnt++;
               pushed++;
            end
         end
      end
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 8'h00, rdy, 0, 0, 0);
   endtask

   // Monitor: values sampled in the active region of the edge are the pre-edge outputs.
   always @(posedge clk) begin
      if (!rst && !flush_in && rd_valid_out === 1'b1 && rd_ready_in) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 1, 0);
         end else begin
            check("pop_data", int'(rd_data_out), int'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check("count", int'(count_out), m_cnt);
      check("valid", int'(rd_valid_out), int'(m_cnt > 0));
      check("overflow", int'(overflow_out), int'(m_ov));
      check("frame_err", int'(frame_err_out), int'(m_fe));
      check("err_count", int'(err_count_out), m_ec);
      if (m_cnt == 0)
         check("empty_data", int'(rd_data_out), 0);
      else if (exp_q.size() > 0)
         check("head_data", int'(rd_data_out), int'(exp_q[0]));
   end

   initial begin
      int guard;
      // reset then a single byte
      step(0, 0, 8'h00, 0, 0, 0, 1);
      step(0, 0, 8'h00, 0, 0, 0, 1);
      step(1, 0, 8'hA5, 0, 0, 0, 0);
      idle(0);
      idle(1);
      idle(1);

      // ordering and wrap: 40 bytes with random pop rate, never overflowing
      pushed = 0;
      guard = 0;
      while (pushed < 40 && guard < 2000) begin
         if (m_cnt < DEPTH && $urandom_range(0, 1) == 1)
            step(1, 0, 8'(pushed), $urandom_range(0, 1) == 1, 0, 0, 0);
         else
            idle($urandom_range(0, 1) == 1);
         guard++;
      end
      check("order_pushed", pushed, 40);
      repeat (DEPTH + 2) idle(1);

      // overflow: fill, push 77 with no pop, drain
      for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h10 + i), 0, 0, 0, 0);
      step(1, 0, 8'h77, 0, 0, 0, 0);
      repeat (DEPTH + 2) idle(1);
      step(0, 0, 8'h00, 0, 0, 1, 0);
      // full with simultaneous pop: 55 accepted and last out
      for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h30 + i), 0, 0, 0, 0);
      step(1, 0, 8'h55, 1, 0, 0, 0);
      repeat (DEPTH + 2) idle(1);

      // framing errors and saturation
      step(1, 0, 8'h01, 0, 0, 1, 0);
      repeat (3) step(1, 1, 8'hFF, 0, 0, 0, 0);
      idle(0);
      repeat (300) step(1, 1, 8'hFF, 0, 0, 0, 0);
      idle(1);

      // clear collisions
      step(1, 1, 8'hFF, 0, 0, 1, 0);
      idle(0);
      step(0, 0, 8'h00, 0, 0, 1, 0);
      idle(0);

      // randomized mixed traffic
      repeat (500)
         step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, 1) == 1, 0, $urandom_range(0, 15) == 0, 0);
      repeat (DEPTH + 2) idle(1);

      // flush mid-stream with simultaneous push and pop, flags retained
      step(1, 1, 8'h00, 0, 0, 0, 0);
      step(1, 0, 8'hEE, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0, 0, 0, 0);
      step(1, 0, 8'h99, 1, 1, 0, 0);
      idle(1);
      step(1, 0, 8'h42, 0, 0, 0, 0);
      idle(1);
      idle(1);

      // reset mid-stream
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hD0 + i), 0, 0, 0, 0);
      step(1, 1, 8'h00, 0, 0, 0, 0);
      step(1, 0, 8'h88, 1, 0, 0, 1);
      idle(0);
      step(1, 0, 8'h3C, 0, 0, 0, 0);
      idle(1);
      idle(1);

      check("scoreboard_drained", exp_q.size(), m_cnt);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed frame from the receiver's one-cycle done pulse and drops frames flagged as erroneous. Good bytes are queued in a first-word-fall-through FIFO and offered to the bus-side peripheral register logic through a valid/ready read port. The block also keeps sticky overflow and framing-error flags and a saturating error counter for software status reads.

## Interface
- DEPTH, 16, FIFO capacity in bytes; power of two, ≥2
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- rx_byte_in  input  8  received byte from UART receiver; valid only while rx_done_in=1
- rx_done_in  input  1  one-cycle pulse, frame complete
- rx_error_in  input  1  frame error flag; sampled in the same cycle as rx_done_in
- rd_data_out  output  8  FIFO head byte; 8'h00 while empty
- rd_valid_out  output  1  FIFO non-empty
- rd_ready_in  input  1  consumer accepts head byte
- count_out  output  $clog2(DEPTH)+1  bytes currently stored, 0..DEPTH
- overflow_out  output  1  sticky; a good byte was dropped because the FIFO was full
- frame_err_out  output  1  sticky; an erroneous frame was received
- err_count_out  output  8  erroneous frames received, saturates at 255
- clear_flags_in  input  1  clears overflow_out, frame_err_out and err_count_out
- flush_in  input  1  empties the FIFO

## Operation
- Storage: DEPTH×8 register array. wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: low bits equal and MSBs differ.
  - count_out = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push condition: rx_done_in & ~rx_error_in & (~full | pop).
- Pop condition: rd_valid_out & rd_ready_in. rd_ready_in while empty has no effect.
- Error frame (rx_done_in & rx_error_in):
  - byte is discarded;
  - frame_err_out ← 1;
  - err_count_out increments, holding at 8'hFF.
- Full drop (rx_done_in & ~rx_error_in & full & ~pop):
  - byte is discarded;
  - overflow_out ← 1;
  - FIFO contents are unchanged.
- Full with simultaneous pop: the push is accepted, count stays DEPTH, no overflow.
- Empty with simultaneous done: no pop occurs; the push proceeds normally.
- Flush (flush_in=1):
  - rd_ptr ← wr_ptr's reset state, i.e. both pointers ← 0;
  - any push or pop in the same cycle is ignored;
  - sticky flags and counter are unaffected.
- Clear (clear_flags_in=1) resets the flags and counter to 0. If a set/increment event occurs in the same cycle, the event wins:
  - flag = 1;
  - counter = 1, since it was cleared and then incremented.
- rd_data_out = mem[rd_ptr low bits] when non-empty, otherwise 8'h00.

## Timing
- Reset (rst=1 at a clk edge): pointers 0, memory contents don't-care. All outputs after reset: rd_valid_out=0, rd_data_out=8'h00, count_out=0, overflow_out=0, frame_err_out=0, err_count_out=0.
- rst mid-operation discards all queued data in the same edge, with no partial pop.
- Latency: a byte pushed at edge N appears at rd_data_out, with rd_valid_out=1 and count_out updated, after edge N. There is no combinational path from rx_* to rd_*.
- Pop at edge N: the next head (or empty) is visible after edge N.
- Sustained throughput: one push and one pop per cycle.
- Sticky flags and err_count_out update at the edge sampling the event; they are visible the next cycle.
- Outputs are registered state or decode of registered state only. The only combinational input-to-state dependency is rd_ready_in gating a full-FIFO push in the same cycle.

## Test plan
- Reset, then single byte: reset → all outputs 0. Pulse done with byte 8'hA5, error=0. Next cycle rd_valid_out=1, rd_data_out=8'hA5, count_out=1. Pop → rd_valid_out=0, rd_data_out=8'h00.
- Ordering and wrap: with DEPTH=16, push 40 bytes 0..39 while popping at random rate without overflow. Popped sequence must be exactly 0..39; count_out must match the model every cycle.
- Overflow: fill with 16 bytes, push 8'h77 with rd_ready_in=0 → overflow_out=1, count_out=16, the popped sequence contains no 8'h77. Repeat full + push 8'h55 with simultaneous pop → no new drop, 8'h55 is last out.
- Framing errors: 3 done pulses with error=1 and byte 8'hFF → count_out unchanged, frame_err_out=1, err_count_out=3. Send 300 errors → err_count_out holds 255.
- Clear collision: clear_flags_in in the same cycle as an error done pulse → frame_err_out=1, err_count_out=1. Clear alone → all flags 0.
- Flush/reset mid-stream: 5 bytes queued, then flush_in with simultaneous push and pop → count_out=0, rd_valid_out=0, flags retained. Repeat with rst → all outputs at reset values.
